// File: rtl/btn_conditioner_if.sv
// Button/switch conditioning bundle.
// Board side drives raw inputs; conditioner returns clean signals.
interface btn_conditioner_if #(
    parameter int N_BTN = 4,
    parameter int N_SW  = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_release;
    logic [N_SW-1:0]  sw_sync;
    logic             multi_press;

    modport master (
        output btn_raw,
        output sw_raw,
        input  btn_level,
        input  btn_pulse,
        input  btn_release,
        input  sw_sync,
        input  multi_press
    );

    modport slave (
        input  btn_raw,
        input  sw_raw,
        output btn_level,
        output btn_pulse,
        output btn_release,
        output sw_sync,
        output multi_press
    );
endinterface

// File: rtl/btn_conditioner.sv
// Button debounce and switch synchroniser feeding the IO FSM.
// One clean level plus press/release pulses per button.
module btn_conditioner #(
    parameter int N_BTN      = 4,
    parameter int N_SW       = 4,
    parameter int DEB_CYCLES = 2000000,
    parameter int CNT_W      = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    btn_conditioner_if.slave  io
);

    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(DEB_CYCLES - 1);

    logic [N_BTN-1:0] btn_s1;
    logic [N_BTN-1:0] btn_s2;
    logic [N_SW-1:0]  sw_s1;
    logic [N_SW-1:0]  sw_s2;

    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] pulse_q;
    logic [N_BTN-1:0] rel_q;

    // Two-flop synchronisers for every raw button and switch bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= io.btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= io.sw_raw;
            sw_s2  <= sw_s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             lvl;
        logic             pls;
        logic             rel;

        // Accept a new level only after DEB_CYCLES differing edges.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
                pls <= 1'b0;
                rel <= 1'b0;
            end else begin
                pls <= 1'b0;
                rel <= 1'b0;
                if (btn_s2[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt <= '0;
                    lvl <= btn_s2[i];
                    pls <= btn_s2[i];
                    rel <= ~btn_s2[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign level_q[i] = lvl;
        assign pulse_q[i] = pls;
        assign rel_q[i]   = rel;
    end

    assign io.btn_level   = level_q;
    assign io.btn_pulse   = pulse_q;
    assign io.btn_release = rel_q;
    assign io.sw_sync     = sw_s2;

    // Clearing the lowest set bit leaves something iff two or more were set.
    assign io.multi_press =
        |(level_q & (level_q - 1'b1));

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a short debounce window.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_btn_conditioner;

    localparam int N_BTN = 4;
    localparam int N_SW  = 4;
    localparam int DEB   = 4;
    localparam int CW    = 3;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    btn_conditioner_if #(.N_BTN(N_BTN), .N_SW(N_SW)) bus ();

    btn_conditioner #(
        .N_BTN     (N_BTN),
        .N_SW      (N_SW),
        .DEB_CYCLES(DEB),
        .CNT_W     (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.btn_raw = '0;
        bus.sw_raw  = '0;
        #1;
        n_chk++;
        if ({bus.btn_level, bus.btn_pulse, bus.btn_release,
             bus.sw_sync, bus.multi_press} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b %b %b %b %b want all 0",
                     bus.btn_level, bus.btn_pulse, bus.btn_release,
                     bus.sw_sync, bus.multi_press);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_chk++;
        if (bus.btn_level !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_level: got %b want 0000",
                     bus.btn_level);
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] el;
        logic [3:0] ep;
        bus.btn_raw = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            el = (k >= 6) ? 4'b0001 : 4'b0000;
            ep = (k == 6) ? 4'b0001 : 4'b0000;
            n_chk++;
            if (bus.btn_level !== el || bus.btn_pulse !== ep
                || bus.btn_release !== 4'b0000) begin
                n_fail++;
                $display("FAIL press_edge%0d: lvl=%b pls=%b rel=%b want %b %b 0000",
                         k, bus.btn_level, bus.btn_pulse,
                         bus.btn_release, el, ep);
            end
        end
        bus.btn_raw = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            el = (k < 6) ? 4'b0001 : 4'b0000;
            ep = (k == 6) ? 4'b0001 : 4'b0000;
            n_chk++;
            if (bus.btn_level !== el || bus.btn_release !== ep
                || bus.btn_pulse !== 4'b0000) begin
                n_fail++;
                $display("FAIL unpress_edge%0d: lvl=%b rel=%b pls=%b want %b %b 0000",
                         k, bus.btn_level, bus.btn_release,
                         bus.btn_pulse, el, ep);
            end
        end
    endtask

    task automatic test_bounce();
        logic pat [16];
        for (int k = 0; k < 16; k++) pat[k] = 1'b0;
        for (int k = 0; k < 3; k++) pat[k] = 1'b1;
        for (int k = 5; k < 8; k++) pat[k] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.btn_raw = {3'b000, pat[k]};
            step();
            n_chk++;
            if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000
                || bus.btn_release !== 4'b0000) begin
                n_fail++;
                $display("FAIL bounce_cyc%0d: lvl=%b pls=%b rel=%b want all 0000",
                         k, bus.btn_level, bus.btn_pulse,
                         bus.btn_release);
            end
        end
    endtask

    task automatic test_bounce_settle();
        int npulse;
        int rise_at;
        npulse  = 0;
        rise_at = -1;
        bus.btn_raw = 4'b0001;
        step();
        step();
        bus.btn_raw = 4'b0000;
        step();
        step();
        bus.btn_raw = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.btn_pulse[0]) npulse++;
            if (bus.btn_level[0] && rise_at < 0) rise_at = k;
        end
        n_chk++;
        if (rise_at !== 6) begin
            n_fail++;
            $display("FAIL settle_rise: got edge %0d want 6", rise_at);
        end
        n_chk++;
        if (npulse !== 1) begin
            n_fail++;
            $display("FAIL settle_pulses: got %0d want 1", npulse);
        end
        bus.btn_raw = 4'b0000;
        for (int k = 0; k < 8; k++) step();
        n_chk++;
        if (bus.btn_level !== 4'b0000) begin
            n_fail++;
            $display("FAIL settle_release: lvl=%b want 0000",
                     bus.btn_level);
        end
    endtask

    task automatic test_simultaneous();
        bus.btn_raw = 4'b1001;
        for (int k = 1; k <= 5; k++) step();
        n_chk++;
        if (bus.btn_level !== 4'b0000 || bus.multi_press !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_early: lvl=%b mp=%b want 0000 0",
                     bus.btn_level, bus.multi_press);
        end
        step();
        n_chk++;
        if (bus.btn_pulse !== 4'b1001 || bus.btn_level !== 4'b1001
            || bus.multi_press !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_pulse: pls=%b lvl=%b mp=%b want 1001 1001 1",
                     bus.btn_pulse, bus.btn_level, bus.multi_press);
        end
        step();
        n_chk++;
        if (bus.btn_pulse !== 4'b0000 || bus.multi_press !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_after: pls=%b mp=%b want 0000 1",
                     bus.btn_pulse, bus.multi_press);
        end
        bus.btn_raw = 4'b1000;
        for (int k = 1; k <= 5; k++) step();
        n_chk++;
        if (bus.multi_press !== 1'b1 || bus.btn_level !== 4'b1001) begin
            n_fail++;
            $display("FAIL simul_hold: mp=%b lvl=%b want 1 1001",
                     bus.multi_press, bus.btn_level);
        end
        step();
        n_chk++;
        if (bus.multi_press !== 1'b0 || bus.btn_release !== 4'b0001
            || bus.btn_level !== 4'b1000) begin
            n_fail++;
            $display("FAIL simul_drop: mp=%b rel=%b lvl=%b want 0 0001 1000",
                     bus.multi_press, bus.btn_release, bus.btn_level);
        end
        bus.btn_raw = 4'b0000;
        for (int k = 0; k < 8; k++) step();
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] el;
        logic [3:0] ep;
        bus.btn_raw = 4'b0010;
        for (int k = 0; k < 8; k++) step();
        n_chk++;
        if (bus.btn_level !== 4'b0010) begin
            n_fail++;
            $display("FAIL hold_before_rst: lvl=%b want 0010",
                     bus.btn_level);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.btn_level !== 4'b0000 || bus.btn_pulse !== 4'b0000
            || bus.btn_release !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async: lvl=%b pls=%b rel=%b want all 0000",
                     bus.btn_level, bus.btn_pulse, bus.btn_release);
        end
        for (int k = 0; k < 3; k++) step();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            el = (k >= 6) ? 4'b0010 : 4'b0000;
            ep = (k == 6) ? 4'b0010 : 4'b0000;
            n_chk++;
            if (bus.btn_level !== el || bus.btn_pulse !== ep
                || bus.btn_release !== 4'b0000) begin
                n_fail++;
                $display("FAIL requal_edge%0d: lvl=%b pls=%b rel=%b want %b %b 0000",
                         k, bus.btn_level, bus.btn_pulse,
                         bus.btn_release, el, ep);
            end
        end
        bus.btn_raw = 4'b0000;
        for (int k = 0; k < 8; k++) step();
    endtask

    task automatic test_switch();
        logic [3:0] exp_s [5];
        exp_s[0] = 4'b0000;
        exp_s[1] = 4'b1010;
        exp_s[2] = 4'b1010;
        exp_s[3] = 4'b1011;
        exp_s[4] = 4'b1010;
        bus.sw_raw = 4'b1010;
        step();
        n_chk++;
        if (bus.sw_sync !== exp_s[0]) begin
            n_fail++;
            $display("FAIL sw_edge1: got %b want %b",
                     bus.sw_sync, exp_s[0]);
        end
        step();
        n_chk++;
        if (bus.sw_sync !== exp_s[1]) begin
            n_fail++;
            $display("FAIL sw_edge2: got %b want %b",
                     bus.sw_sync, exp_s[1]);
        end
        bus.sw_raw = 4'b1011;
        step();
        bus.sw_raw = 4'b1010;
        n_chk++;
        if (bus.sw_sync !== exp_s[2]) begin
            n_fail++;
            $display("FAIL sw_glitch1: got %b want %b",
                     bus.sw_sync, exp_s[2]);
        end
        step();
        n_chk++;
        if (bus.sw_sync !== exp_s[3]) begin
            n_fail++;
            $display("FAIL sw_glitch2: got %b want %b",
                     bus.sw_sync, exp_s[3]);
        end
        step();
        n_chk++;
        if (bus.sw_sync !== exp_s[4]) begin
            n_fail++;
            $display("FAIL sw_glitch3: got %b want %b",
                     bus.sw_sync, exp_s[4]);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.btn_raw = '0;
        bus.sw_raw  = '0;
        step();
        test_reset();
        test_clean_press();
        test_bounce();
        test_bounce_settle();
        test_simultaneous();
        test_reset_mid_hold();
        test_switch();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
